data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter WORDS, default 1024; number of 32-bit words stored (byte capacity 4*WORDS).
REQ-002 SHALL have parameter LATENCY, default 4, legal range 1..8; cycles from address sample to read data valid.
REQ-003 SHALL have port clk, input, 1; single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_b, input, 1; reset, synchronous, active-low.
REQ-005 SHALL have port mem_addr, input, 32; byte address from core.
REQ-006 SHALL have port mem_data_in, input, 4 x 8 (byte array [0:3]); write data from core.
REQ-007 SHALL have port mem_write_en, input, 1; write request for the current cycle.
REQ-008 SHALL have port mem_data_out, output, 4 x 8 (byte array [0:3]); read data to core.
REQ-009 SHALL have port mem_ready, output, 1; mem_data_out valid for the current mem_addr.
REQ-010 SHALL have port addr_error, output, 1; sticky flag, out-of-range access seen.

Function
REQ-011 SHALL decode word index as mem_addr[31:2]; mem_addr[1:0] ignored for storage.
REQ-012 SHALL map byte lane i (mem_data_in[i] / mem_data_out[i]) to byte address 4*index+i.
REQ-013 SHALL treat index >= WORDS as out of range: write dropped, read data 0, addr_error set at next edge.
REQ-014 SHALL, on each edge with rst_b=1 and mem_write_en=1 and index in range, commit all 4 bytes of mem_data_in.
REQ-015 SHALL sample {mem_addr index, range flag} every cycle into a LATENCY-deep shift pipeline.
REQ-016 SHALL drive mem_data_out with the word at the index leaving the pipeline tail, read from storage at that tail cycle, so writes committed after sampling but before output are visible.
REQ-017 SHALL keep a saturating stability counter (0..LATENCY): +1 per edge when mem_addr equals previous-cycle mem_addr and mem_write_en=0; otherwise load 0.
REQ-018 SHALL assert mem_ready combinationally when counter = LATENCY and mem_write_en=0.
REQ-019 SHALL drop mem_ready in the same cycle mem_addr changes or mem_write_en rises.
REQ-020 SHALL treat a write followed by a read of the same address as read-after-write: the read returns new data once mem_ready=1.
REQ-021 SHALL accept a write every cycle (back-to-back writes, last write to an index wins).
REQ-022 SHALL keep addr_error set until reset.

Reset
REQ-023 SHALL, on edge with rst_b=0: clear pipeline, counter, addr_error; mem_data_out=0, mem_ready=0 from the following cycle.
REQ-024 SHALL retain storage contents across reset; writes during rst_b=0 SHALL be ignored.
REQ-025 SHALL restart the stability count from 0 when reset deasserts mid-access; no stale pipeline data becomes valid early.

Verification
REQ-026 Reset, then hold addr 0x10 with storage word 4 = {0x11,0x22,0x33,0x44} -> mem_ready=1 after exactly 4 stable cycles, mem_data_out = {0x11,0x22,0x33,0x44}.
REQ-027 Write {0xDE,0xAD,0xBE,0xEF} to 0x20 one cycle, then hold read of 0x20 -> after 4 cycles mem_ready=1, data {0xDE,0xAD,0xBE,0xEF}.
REQ-028 Hold 0x10 for 2 cycles, change to 0x14 -> mem_ready stays 0, asserts 4 cycles after change with word 5.
REQ-029 Read 0x1000 (index 1024, WORDS=1024) -> data 0, addr_error=1 next cycle, remains 1 until rst_b=0.
REQ-030 Write 0x55555555 to 0x8, pulse rst_b=0 one cycle, read 0x8 -> mem_ready low during reset, then 0x55 in all lanes after 4 stable cycles.
REQ-031 Write 0x01.. then 0x02.. to 0x30 on consecutive cycles, read 0x30 -> all lanes 0x02.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Word-organised data memory with a fixed read latency and a
//            stability-qualified ready flag. The core presents a byte
//            address and holds it. Read data is valid once the address has
//            been stable, with no write, for LATENCY cycles. Writes commit
//            all four byte lanes in a single cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORDS        : number of 32-bit words stored (byte capacity 4*WORDS)
//   LATENCY      : address-sample to data-valid delay in cycles (1..8)
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst_b        : synchronous reset, active low
//   mem_addr     : byte address; bits [31:2] select the word
//   mem_data_in  : write data; lane i goes to byte address 4*index+i
//   mem_write_en : write request for the current cycle
//   mem_data_out : read data; lane i comes from byte address 4*index+i
//   mem_ready    : mem_data_out is valid for the current mem_addr
//   addr_error   : sticky flag; an out-of-range access has been seen
// ============================================================================
module data_memory #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in  [0:3],
  input  logic        mem_write_en,
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        addr_error
);

  localparam int              c_AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int              c_CW    = $clog2(LATENCY + 1);
  localparam logic [29:0]     c_WORDS = 30'(WORDS);
  localparam logic [c_CW-1:0] c_LAT   = c_CW'(LATENCY);

  // Storage is deliberately not reset: contents survive a reset pulse.
  logic [3:0][7:0]  r_mem       [0:WORDS-1];
  logic [c_AW-1:0]  r_pipe_idx  [0:LATENCY-1];
  logic             r_pipe_ok   [0:LATENCY-1];
  logic [31:0]      r_prev_addr;
  logic [c_CW-1:0]  r_stable_cnt;
  logic             r_addr_error;

  logic [29:0]      w_idx;
  logic             w_in_range;
  logic [c_AW-1:0]  w_mem_idx;
  logic             w_addr_same;
  logic [c_AW-1:0]  w_tail_idx;
  logic             w_tail_ok;

  assign w_idx       = mem_addr[31:2];
  assign w_in_range  = (w_idx < c_WORDS);
  assign w_mem_idx   = w_idx[c_AW-1:0];
  assign w_addr_same = (mem_addr == r_prev_addr);
  assign w_tail_idx  = r_pipe_idx[LATENCY-1];
  assign w_tail_ok   = r_pipe_ok[LATENCY-1];

  // Write port: out-of-range writes and writes under reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_b && mem_write_en && w_in_range) begin
      r_mem[w_mem_idx] <= {mem_data_in[3], mem_data_in[2],
                           mem_data_in[1], mem_data_in[0]};
    end
  end

  // Address pipeline: the index and its range flag are sampled every cycle.
  // Only the index is carried; storage itself is read at the tail so that
  // writes landing while the address is in flight are seen by the read.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_pipe_idx[k] <= '0;
        r_pipe_ok[k]  <= 1'b0;
      end
    end else begin
      r_pipe_idx[0] <= w_mem_idx;
      r_pipe_ok[0]  <= w_in_range;
      for (int k = 1; k < LATENCY; k++) begin
        r_pipe_idx[k] <= r_pipe_idx[k-1];
        r_pipe_ok[k]  <= r_pipe_ok[k-1];
      end
    end
  end

  // Previous-cycle address is tracked through reset too, so the count can
  // resume immediately after reset releases on an address held across it.
  always_ff @(posedge clk) begin
    r_prev_addr <= mem_addr;
  end

  // Saturating stability counter: counts edges with an unchanged address and
  // no write; any change or write restarts it from zero.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_stable_cnt <= '0;
    end else if (w_addr_same && !mem_write_en) begin
      if (r_stable_cnt != c_LAT) begin
        r_stable_cnt <= r_stable_cnt + 1'b1;
      end
    end else begin
      r_stable_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_addr_error <= 1'b0;
    end else if (!w_in_range) begin
      r_addr_error <= 1'b1;
    end
  end

  // Out-of-range (or cleared) pipeline slots read as zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i] = 8'h00;
      if (w_tail_ok) begin
        mem_data_out[i] = r_mem[w_tail_idx][i];
      end
    end
  end

  // The live address compare drops ready in the very cycle the address moves,
  // before the counter has had an edge to react.
  assign mem_ready  = rst_b && !mem_write_en && w_addr_same &&
                      (r_stable_cnt == c_LAT);
  assign addr_error = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Self-checking bench for data_memory. Stimulus pushes expected
//            read words into a queue. A negedge monitor derives ready and
//            error from a windowed history of sampled inputs. It pops and
//            compares the expected word when a read becomes valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int WORDS = 1024;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic        mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic        mem_ready;
  logic        addr_error;

  always #5 clk = ~clk;

  data_memory #(.WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready),
    .addr_error   (addr_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        rst;
  } samp_t;

  samp_t       hist[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:WORDS-1];   // lane 0 in bits [31:24]
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          err_exp  = 1'b0;
  bit          started  = 1'b0;
  bit          prev_exp_ready = 1'b0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Record what the DUT sees at every rising edge.
  always @(posedge clk) begin
    hist.push_back('{mem_addr, mem_write_en, rst_b});
    if (hist.size() > 16) void'(hist.pop_front());
    if (!rst_b) begin
      err_exp = 1'b0;
      started = 1'b1;
    end else if (mem_addr[31:2] >= 30'(WORDS)) begin
      err_exp = 1'b1;
    end
  end

  // Data is valid once the last LAT edges were out of reset, write-free,
  // and each saw the same address as the edge before it, and the address
  // is still unchanged now.
  function automatic bit model_ready();
    int n = hist.size();
    if (!rst_b || mem_write_en || n < LAT + 1) return 1'b0;
    if (mem_addr !== hist[n-1].addr) return 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (hist[n-1-k].rst !== 1'b1 || hist[n-1-k].we !== 1'b0 ||
          hist[n-1-k].addr !== hist[n-2-k].addr) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] dout_word();
    return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  endfunction

  always @(negedge clk) begin
    bit exp_r;
    if (started) begin
      exp_r = model_ready();
      check("mem_ready", {31'd0, mem_ready}, {31'd0, exp_r});
      check("addr_error", {31'd0, addr_error}, {31'd0, err_exp});
      if (hist[$].rst == 1'b0) check("data_after_reset", dout_word(), 32'h0);
      if (exp_r && !prev_exp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'h1, 32'h0);
        end else begin
          check("read_data", dout_word(), exp_q.pop_front());
        end
      end
      prev_exp_ready = exp_r;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] w);
    mem_addr     = a;
    mem_write_en = 1'b1;
    for (int i = 0; i < 4; i++) mem_data_in[i] = w[31-8*i -: 8];
    @(posedge clk);
    if (rst_b && a[31:2] < 30'(WORDS)) ref_mem[a[31:2]] = w;
    #1;
    mem_write_en = 1'b0;
    last_addr    = a;
  endtask

  // A full read (LAT+2 cycles) always reaches ready and queues its word.
  task automatic do_read(input logic [31:0] a, input int cycles);
    mem_addr     = a;
    mem_write_en = 1'b0;
    if (cycles >= LAT + 2)
      exp_q.push_back((a[31:2] < 30'(WORDS)) ? ref_mem[a[31:2]] : 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    last_addr = a;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b     = 1'b1;
    last_addr = 32'hFFFF_FFFF;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst_b        = 1'b0;
    mem_addr     = 32'h0;
    mem_write_en = 1'b0;
    for (int i = 0; i < 4; i++) mem_data_in[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Fill the words the random phase will touch.
    for (int w = 0; w < 32; w++) do_write(32'(w) << 2, $urandom);

    // Directed scenarios.
    do_write(32'h10, 32'h11223344);
    do_reset();
    do_read(32'h10, LAT + 2);                 // word 4 after stable hold
    do_write(32'h20, 32'hDEADBEEF);
    do_read(32'h20, LAT + 2);                 // read-after-write
    do_read(32'h10, 2);                       // aborted read
    do_read(32'h14, LAT + 2);                 // word 5
    do_read(32'h1000, LAT + 2);               // out of range: zero + error
    do_read(32'h0C, LAT + 2);                 // error stays sticky
    do_write(32'h8, 32'h55555555);
    mem_addr = 32'h8;
    do_reset();
    do_read(32'h8, LAT + 2);
    do_write(32'h30, 32'h01010101);
    do_write(32'h30, 32'h02020202);
    do_read(32'h30, LAT + 2);
    rst_b = 1'b0;                             // write under reset is ignored
    do_write(32'h30, 32'hCAFEF00D);
    rst_b = 1'b1;
    do_read(32'h30, LAT + 2);

    // Randomized phase.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0)
        a = {$urandom_range(WORDS, WORDS + 64), 2'($urandom)};
      else
        a = {30'($urandom_range(0, 31)), 2'($urandom)};
      if (r < 35) begin
        do_write(a, $urandom);
      end else if (r < 95) begin
        while (a == last_addr) a = {30'($urandom_range(0, 31)), 2'($urandom)};
        do_read(a, (r < 85) ? LAT + 2 : $urandom_range(1, LAT - 1));
      end else begin
        do_reset();
      end
    end

    do_read(32'h0, 3);
    check("pending_outputs", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
